// File: rtl/rv_wb_pkg.sv
// Shared types and constants for the single-master Wishbone decoder.
//   wb_state_t  : decoder FSM state encoding (IDLE -> ACTIVE -> RESP -> IDLE)
//   wb_req_t    : registered master request (address, write data, we, byte select)
//   WB_ERR_DATA : default read data returned on an error completion
package rv_wb_pkg;

    typedef enum logic [1:0] {
        WB_IDLE   = 2'd0,
        WB_ACTIVE = 2'd1,
        WB_RESP   = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
    } wb_req_t;

    localparam logic [31:0] WB_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/rv_wb_addr_dec.sv
// Combinational region decoder.
//   i_region : region-select field taken from the master address
//   o_hit    : 1 when some slave's region code matches i_region
//   o_idx    : index of the matching slave; the lowest index wins on overlap
module rv_wb_addr_dec #(
    parameter int                     NSLV       = 4,
    parameter int                     SELW       = 4,
    parameter logic [NSLV*SELW-1:0]   SLV_REGION = {4'h3, 4'h2, 4'h1, 4'h0},
    parameter int                     IDXW       = 2
) (
    input  logic [SELW-1:0] i_region,
    output logic            o_hit,
    output logic [IDXW-1:0] o_idx
);

    // Scan from the top index down so the last assignment is the lowest match.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int k = NSLV - 1; k >= 0; k--) begin
            if (i_region == SLV_REGION[k*SELW +: SELW]) begin
                o_hit = 1'b1;
                o_idx = IDXW'(k);
            end
        end
    end

endmodule

// File: rtl/rv_wb_decoder.sv
// Single-master Wishbone classic interconnect.
// Registers the master request, decodes the region field, forwards the request
// to one of NSLV slaves and returns read data plus a one-cycle ack. Unmapped
// addresses and slave timeouts complete with an error ack (o_bus_err pulse,
// ERR_DATA on reads) so the master never hangs.
//   i_clk, i_reset_n          : clock, asynchronous active-low reset
//   i_m_* / o_m_*             : master side (adr, dat, we, sel, stb, cyc, ack)
//   o_s_adr/dat/we/sel        : registered request, shared by all slaves
//   o_s_stb / o_s_cyc         : per-slave strobe/cycle, one-hot or zero
//   i_s_dat / i_s_ack         : per-slave read data (slave k at [32k+31:32k]) and ack
//   o_bus_err                 : one-cycle pulse alongside an error ack
//   o_err_adr                 : sticky address of the most recent error access
//
// Handshake: a request is taken when i_m_cyc & i_m_stb are seen high in IDLE;
// the master keeps stb/cyc high until it sees o_m_ack. A slave completes when
// its i_s_ack is high while its o_s_stb is high. Dropping i_m_cyc before the
// ack abandons the access with no ack and no error.
module rv_wb_decoder
    import rv_wb_pkg::*;
#(
    parameter int   NSLV       = 4,
    parameter int   SEL_HI     = 31,
    parameter int   SEL_LO     = 28,
    parameter logic [NSLV*(SEL_HI-SEL_LO+1)-1:0] SLV_REGION = {4'h3, 4'h2, 4'h1, 4'h0},
    parameter int   TIMEOUT    = 255,
    parameter logic [31:0] ERR_DATA = WB_ERR_DATA
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic [31:0]         i_m_adr,
    input  logic [31:0]         i_m_dat,
    output logic [31:0]         o_m_dat,
    input  logic                i_m_we,
    input  logic [3:0]          i_m_sel,
    input  logic                i_m_stb,
    input  logic                i_m_cyc,
    output logic                o_m_ack,
    output logic [31:0]         o_s_adr,
    output logic [31:0]         o_s_dat,
    output logic                o_s_we,
    output logic [3:0]          o_s_sel,
    output logic [NSLV-1:0]     o_s_stb,
    output logic [NSLV-1:0]     o_s_cyc,
    input  logic [NSLV*32-1:0]  i_s_dat,
    input  logic [NSLV-1:0]     i_s_ack,
    output logic                o_bus_err,
    output logic [31:0]         o_err_adr
);

    localparam int SELW = SEL_HI - SEL_LO + 1;
    localparam int IDXW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int CNTW = $clog2(TIMEOUT + 1);

    wb_state_t          state_q, state_d;
    wb_req_t            req_q, req_d;
    logic [IDXW-1:0]    idx_q, idx_d;
    logic [NSLV-1:0]    stb_q, stb_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [31:0]        mdat_q, mdat_d;
    logic [31:0]        err_adr_q, err_adr_d;

    logic               dec_hit;
    logic [IDXW-1:0]    dec_idx;
    logic               sel_ack;
    logic [31:0]        sel_dat;
    logic [CNTW-1:0]    cnt_inc;

    rv_wb_addr_dec #(
        .NSLV       (NSLV),
        .SELW       (SELW),
        .SLV_REGION (SLV_REGION),
        .IDXW       (IDXW)
    ) u_addr_dec (
        .i_region   (i_m_adr[SEL_HI:SEL_LO]),
        .o_hit      (dec_hit),
        .o_idx      (dec_idx)
    );

    // Ack and read data of the currently selected slave only; other acks are ignored.
    always_comb begin
        sel_ack = 1'b0;
        sel_dat = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (idx_q == IDXW'(k)) begin
                sel_ack = i_s_ack[k];
                sel_dat = i_s_dat[32*k +: 32];
            end
        end
    end

    assign cnt_inc = cnt_q + CNTW'(1);

    // Ack, error pulse and master read data are registered on the transition
    // into RESP, so they are high exactly for the one RESP cycle.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        idx_d     = idx_q;
        stb_d     = stb_q;
        cnt_d     = cnt_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        mdat_d    = '0;
        err_adr_d = err_adr_q;

        case (state_q)
            WB_IDLE: begin
                if (i_m_cyc && i_m_stb) begin
                    req_d.adr = i_m_adr;
                    req_d.dat = i_m_dat;
                    req_d.we  = i_m_we;
                    req_d.sel = i_m_sel;
                    if (dec_hit) begin
                        idx_d   = dec_idx;
                        stb_d   = NSLV'(1) << dec_idx;
                        cnt_d   = '0;
                        state_d = WB_ACTIVE;
                    end else begin
                        ack_d     = 1'b1;
                        err_d     = 1'b1;
                        mdat_d    = i_m_we ? 32'h0 : ERR_DATA;
                        err_adr_d = i_m_adr;
                        state_d   = WB_RESP;
                    end
                end
            end

            WB_ACTIVE: begin
                cnt_d = cnt_inc;
                if (!i_m_cyc) begin
                    // Master abandoned the cycle: release the slave silently.
                    stb_d   = '0;
                    state_d = WB_IDLE;
                end else if (sel_ack) begin
                    // Checked before the timeout so a last-cycle ack still completes cleanly.
                    stb_d   = '0;
                    ack_d   = 1'b1;
                    mdat_d  = req_q.we ? 32'h0 : sel_dat;
                    state_d = WB_RESP;
                end else if (cnt_inc == CNTW'(TIMEOUT)) begin
                    stb_d     = '0;
                    ack_d     = 1'b1;
                    err_d     = 1'b1;
                    mdat_d    = req_q.we ? 32'h0 : ERR_DATA;
                    err_adr_d = req_q.adr;
                    state_d   = WB_RESP;
                end
            end

            WB_RESP: begin
                state_d = WB_IDLE;
            end

            default: begin
                stb_d   = '0;
                state_d = WB_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= WB_IDLE;
            req_q     <= '0;
            idx_q     <= '0;
            stb_q     <= '0;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            mdat_q    <= '0;
            err_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            idx_q     <= idx_d;
            stb_q     <= stb_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            mdat_q    <= mdat_d;
            err_adr_q <= err_adr_d;
        end
    end

    assign o_m_dat   = mdat_q;
    assign o_m_ack   = ack_q;
    assign o_s_adr   = req_q.adr;
    assign o_s_dat   = req_q.dat;
    assign o_s_we    = req_q.we;
    assign o_s_sel   = req_q.sel;
    assign o_s_stb   = stb_q;
    assign o_s_cyc   = stb_q;
    assign o_bus_err = err_q;
    assign o_err_adr = err_adr_q;

endmodule

// File: tb/tb_rv_wb_decoder.sv
// Directed bench for rv_wb_decoder with default parameters (4 slaves, TIMEOUT=255).
module tb_rv_wb_decoder;

    logic         clk;
    logic         rst_n;
    logic [31:0]  m_adr;
    logic [31:0]  m_dat_w;
    logic [31:0]  m_dat_r;
    logic         m_we;
    logic [3:0]   m_sel;
    logic         m_stb;
    logic         m_cyc;
    logic         m_ack;
    logic [31:0]  s_adr;
    logic [31:0]  s_dat_w;
    logic         s_we;
    logic [3:0]   s_sel;
    logic [3:0]   s_stb;
    logic [3:0]   s_cyc;
    logic [127:0] s_dat_r;
    logic [3:0]   s_ack;
    logic         bus_err;
    logic [31:0]  err_adr;

    int total = 0;
    int bad   = 0;

    // slave model configuration: wait states before ack (-1 = never acks) and read data
    int          s_wait [4];
    logic [31:0] s_rdata[4];
    int          s_cnt  [4];

    // monitor counters sampled on the falling edge
    int ack_cnt = 0;
    int err_cnt = 0;
    int stb_cnt [4];

    rv_wb_decoder dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_m_adr   (m_adr),
        .i_m_dat   (m_dat_w),
        .o_m_dat   (m_dat_r),
        .i_m_we    (m_we),
        .i_m_sel   (m_sel),
        .i_m_stb   (m_stb),
        .i_m_cyc   (m_cyc),
        .o_m_ack   (m_ack),
        .o_s_adr   (s_adr),
        .o_s_dat   (s_dat_w),
        .o_s_we    (s_we),
        .o_s_sel   (s_sel),
        .o_s_stb   (s_stb),
        .o_s_cyc   (s_cyc),
        .i_s_dat   (s_dat_r),
        .i_s_ack   (s_ack),
        .o_bus_err (bus_err),
        .o_err_adr (err_adr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // slave model: counts strobe cycles, acks combinationally after s_wait cycles
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (s_stb[k]) s_cnt[k] <= s_cnt[k] + 1;
            else          s_cnt[k] <= 0;
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            s_ack[k] = s_stb[k] && (s_wait[k] >= 0) && (s_cnt[k] == s_wait[k]);
            s_dat_r[32*k +: 32] = s_rdata[k];
        end
    end

    always @(negedge clk) begin
        if (m_ack)   ack_cnt <= ack_cnt + 1;
        if (bus_err) err_cnt <= err_cnt + 1;
        for (int k = 0; k < 4; k++)
            if (s_stb[k]) stb_cnt[k] <= stb_cnt[k] + 1;
    end

    // driver: starts at a falling edge, returns at the falling edge where ack is seen
    task automatic wb_xfer(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                           input logic [3:0] sel, input bit keep, input int max_cyc,
                           output int lat, output logic [31:0] rdat, output logic berr);
        m_adr   = adr;
        m_dat_w = dat;
        m_we    = we;
        m_sel   = sel;
        m_stb   = 1'b1;
        m_cyc   = 1'b1;
        lat     = 0;
        rdat    = '0;
        berr    = 1'b0;
        while (lat < max_cyc) begin
            @(negedge clk);
            lat++;
            if (m_ack) begin
                rdat = m_dat_r;
                berr = bus_err;
                break;
            end
        end
        if (!m_ack) begin
            total++; bad++;
            $display("FAIL xfer_timeout adr=%h: no ack within %0d cycles", adr, max_cyc);
            lat = -1;
        end
        if (!keep || lat < 0) begin
            m_stb = 1'b0;
            m_cyc = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_adr = '0; m_dat_w = '0; m_we = 1'b0; m_sel = '0; m_stb = 1'b0; m_cyc = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_wait[k] = 0; s_rdata[k] = '0; stb_cnt[k] = 0; s_cnt[k] = 0;
        end
        repeat (3) @(negedge clk);
        total++; if (m_ack !== 1'b0)   begin bad++; $display("FAIL reset_ack got=%b exp=0", m_ack); end
        total++; if (m_dat_r !== '0)   begin bad++; $display("FAIL reset_mdat got=%h exp=0", m_dat_r); end
        total++; if (s_stb !== 4'b0 || s_cyc !== 4'b0) begin bad++; $display("FAIL reset_stb got=%b/%b exp=0", s_stb, s_cyc); end
        total++; if (bus_err !== 1'b0 || err_adr !== '0) begin bad++; $display("FAIL reset_err got=%b/%h exp=0/0", bus_err, err_adr); end
        total++; if (s_adr !== '0 || s_dat_w !== '0 || s_we !== 1'b0 || s_sel !== '0) begin
            bad++; $display("FAIL reset_sbus got=%h/%h/%b/%b exp=0", s_adr, s_dat_w, s_we, s_sel); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_hit();
        int lat; logic [31:0] rd; logic be; int a0, s1, s_all;
        s_wait[1] = 0; s_rdata[1] = 32'h1234_5678;
        a0 = ack_cnt; s1 = stb_cnt[1]; s_all = stb_cnt[0] + stb_cnt[2] + stb_cnt[3];
        wb_xfer(32'h1000_0010, 32'h0, 1'b0, 4'hF, 1'b0, 20, lat, rd, be);
        repeat (2) @(negedge clk);
        total++; if (lat !== 2) begin bad++; $display("FAIL read_hit_latency got=%0d exp=2", lat); end
        total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL read_hit_data got=%h exp=12345678", rd); end
        total++; if (be !== 1'b0) begin bad++; $display("FAIL read_hit_err got=%b exp=0", be); end
        total++; if (stb_cnt[1] - s1 !== 1) begin bad++; $display("FAIL read_hit_stb1 got=%0d exp=1", stb_cnt[1] - s1); end
        total++; if (stb_cnt[0] + stb_cnt[2] + stb_cnt[3] - s_all !== 0) begin
            bad++; $display("FAIL read_hit_other_stb got=%0d exp=0", stb_cnt[0] + stb_cnt[2] + stb_cnt[3] - s_all); end
        total++; if (ack_cnt - a0 !== 1) begin bad++; $display("FAIL read_hit_ack_count got=%0d exp=1", ack_cnt - a0); end
    endtask

    task automatic test_write_wait();
        int lat; int stable; int a0;
        s_wait[2] = 3; s_rdata[2] = 32'hFFFF_0000;
        a0 = ack_cnt; stable = 0; lat = 0;
        m_adr = 32'h2000_0004; m_dat_w = 32'hA5A5_A5A5; m_we = 1'b1; m_sel = 4'b0011;
        m_stb = 1'b1; m_cyc = 1'b1;
        while (lat < 20 && !m_ack) begin
            @(negedge clk);
            lat++;
            if (s_stb == 4'b0100 && s_cyc == 4'b0100 && s_adr == 32'h2000_0004 &&
                s_dat_w == 32'hA5A5_A5A5 && s_sel == 4'b0011 && s_we == 1'b1)
                stable++;
        end
        m_stb = 1'b0; m_cyc = 1'b0;
        total++; if (lat !== 5) begin bad++; $display("FAIL write_latency got=%0d exp=5", lat); end
        total++; if (m_ack !== 1'b1 || bus_err !== 1'b0) begin bad++; $display("FAIL write_ack got=%b/%b exp=1/0", m_ack, bus_err); end
        repeat (3) @(negedge clk);
        total++; if (stable !== 4) begin bad++; $display("FAIL write_stable_cycles got=%0d exp=4", stable); end
        total++; if (ack_cnt - a0 !== 1) begin bad++; $display("FAIL write_ack_count got=%0d exp=1", ack_cnt - a0); end
    endtask

    task automatic test_unmapped();
        int lat; logic [31:0] rd; logic be; int s_all, e0;
        s_all = stb_cnt[0] + stb_cnt[1] + stb_cnt[2] + stb_cnt[3]; e0 = err_cnt;
        wb_xfer(32'h8000_0000, 32'h0, 1'b0, 4'hF, 1'b0, 20, lat, rd, be);
        @(negedge clk);
        total++; if (lat !== 1) begin bad++; $display("FAIL unmapped_latency got=%0d exp=1", lat); end
        total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL unmapped_data got=%h exp=deadbeef", rd); end
        total++; if (be !== 1'b1) begin bad++; $display("FAIL unmapped_err got=%b exp=1", be); end
        total++; if (err_adr !== 32'h8000_0000) begin bad++; $display("FAIL unmapped_err_adr got=%h exp=80000000", err_adr); end
        total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL unmapped_err_pulse got=%0d exp=1", err_cnt - e0); end
        // error write: completes with error, no slave strobed
        wb_xfer(32'h4000_0100, 32'h1111_2222, 1'b1, 4'hF, 1'b0, 20, lat, rd, be);
        @(negedge clk);
        total++; if (lat !== 1 || be !== 1'b1) begin bad++; $display("FAIL unmapped_write got lat=%0d err=%b exp=1/1", lat, be); end
        total++; if (err_adr !== 32'h4000_0100) begin bad++; $display("FAIL unmapped_write_adr got=%h exp=40000100", err_adr); end
        total++; if (stb_cnt[0] + stb_cnt[1] + stb_cnt[2] + stb_cnt[3] - s_all !== 0) begin
            bad++; $display("FAIL unmapped_no_stb got=%0d exp=0", stb_cnt[0] + stb_cnt[1] + stb_cnt[2] + stb_cnt[3] - s_all); end
    endtask

    task automatic test_timeout();
        int lat; logic [31:0] rd; logic be; int s0;
        s_wait[0] = -1;
        s0 = stb_cnt[0];
        wb_xfer(32'h0000_0040, 32'h0, 1'b0, 4'hF, 1'b0, 400, lat, rd, be);
        @(negedge clk);
        total++; if (stb_cnt[0] - s0 !== 255) begin bad++; $display("FAIL timeout_stb_cycles got=%0d exp=255", stb_cnt[0] - s0); end
        total++; if (lat !== 256) begin bad++; $display("FAIL timeout_latency got=%0d exp=256", lat); end
        total++; if (rd !== 32'hDEAD_BEEF || be !== 1'b1) begin bad++; $display("FAIL timeout_resp got=%h/%b exp=deadbeef/1", rd, be); end
        total++; if (err_adr !== 32'h0000_0040) begin bad++; $display("FAIL timeout_err_adr got=%h exp=00000040", err_adr); end
    endtask

    task automatic test_abort();
        int s3, a0, e0;
        s_wait[3] = -1;
        s3 = stb_cnt[3]; a0 = ack_cnt; e0 = err_cnt;
        m_adr = 32'h3000_0000; m_dat_w = '0; m_we = 1'b0; m_sel = 4'hF;
        m_stb = 1'b1; m_cyc = 1'b1;
        repeat (3) @(negedge clk);
        m_stb = 1'b0; m_cyc = 1'b0;
        @(negedge clk);
        total++; if (s_stb !== 4'b0 || s_cyc !== 4'b0) begin bad++; $display("FAIL abort_stb_drop got=%b/%b exp=0", s_stb, s_cyc); end
        repeat (4) @(negedge clk);
        total++; if (stb_cnt[3] - s3 !== 3) begin bad++; $display("FAIL abort_stb_cycles got=%0d exp=3", stb_cnt[3] - s3); end
        total++; if (ack_cnt - a0 !== 0 || err_cnt - e0 !== 0) begin
            bad++; $display("FAIL abort_no_ack got ack=%0d err=%0d exp=0/0", ack_cnt - a0, err_cnt - e0); end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2; logic [31:0] rd1, rd2; logic be1, be2; int a0, s0, s3;
        // reset while slave 0 is strobed and never acks
        s_wait[0] = -1;
        a0 = ack_cnt;
        m_adr = 32'h0000_0020; m_we = 1'b0; m_sel = 4'hF; m_stb = 1'b1; m_cyc = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (s_stb !== 4'b0001) begin bad++; $display("FAIL midreset_pre_stb got=%b exp=0001", s_stb); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (s_stb !== 4'b0 || s_cyc !== 4'b0) begin bad++; $display("FAIL midreset_stb got=%b/%b exp=0", s_stb, s_cyc); end
        total++; if (err_adr !== '0 || s_adr !== '0 || m_ack !== 1'b0 || bus_err !== 1'b0 || m_dat_r !== '0) begin
            bad++; $display("FAIL midreset_outputs got=%h/%h/%b/%b/%h exp=0", err_adr, s_adr, m_ack, bus_err, m_dat_r); end
        m_stb = 1'b0; m_cyc = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (ack_cnt - a0 !== 0) begin bad++; $display("FAIL midreset_no_ack got=%0d exp=0", ack_cnt - a0); end
        // back-to-back reads: stb held high across the first ack
        s_wait[3] = 1; s_rdata[3] = 32'h3333_CCCC;
        s_wait[0] = 0; s_rdata[0] = 32'h0000_F00D;
        a0 = ack_cnt; s0 = stb_cnt[0]; s3 = stb_cnt[3];
        wb_xfer(32'h3000_0008, 32'h0, 1'b0, 4'hF, 1'b1, 20, lat1, rd1, be1);
        wb_xfer(32'h0000_000C, 32'h0, 1'b0, 4'hF, 1'b0, 20, lat2, rd2, be2);
        repeat (3) @(negedge clk);
        total++; if (rd1 !== 32'h3333_CCCC || be1 !== 1'b0) begin bad++; $display("FAIL b2b_read3 got=%h/%b exp=3333cccc/0", rd1, be1); end
        total++; if (rd2 !== 32'h0000_F00D || be2 !== 1'b0) begin bad++; $display("FAIL b2b_read0 got=%h/%b exp=0000f00d/0", rd2, be2); end
        total++; if (lat1 !== 3 || lat2 !== 3) begin bad++; $display("FAIL b2b_latency got=%0d/%0d exp=3/3", lat1, lat2); end
        total++; if (ack_cnt - a0 !== 2) begin bad++; $display("FAIL b2b_ack_count got=%0d exp=2", ack_cnt - a0); end
        total++; if (stb_cnt[3] - s3 !== 2 || stb_cnt[0] - s0 !== 1) begin
            bad++; $display("FAIL b2b_stb_cycles got=%0d/%0d exp=2/1", stb_cnt[3] - s3, stb_cnt[0] - s0); end
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_write_wait();
        test_unmapped();
        test_timeout();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
